// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the access legality check used at request accept.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_RESP
   } lsu_state_e;

   // High when the width code is illegal for the direction or the address is misaligned.
   function automatic logic lsu_access_err(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = addr_lo[0];
         F3_W:    err = |addr_lo;
         F3_BU:   err = is_store;
         F3_HU:   err = is_store | addr_lo[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response handshake of the load/store unit.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a memory word and extends it
// according to the load width code.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'(rdata >> {addr_lo, 3'b000});
      half_v = 16'(rdata >> {addr_lo[1], 4'b0000});
      case (funct3)
         F3_B:    result = {{24{byte_v[7]}}, byte_v};
         F3_BU:   result = {24'h000000, byte_v};
         F3_H:    result = {{16{half_v[15]}}, half_v};
         F3_HU:   result = {16'h0000, half_v};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between the execute stage and a
// single-port word memory with 1-cycle read latency.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.slave  req_bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rstrb,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rstrb_q, mem_rstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wmask_q, mem_wmask_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic              access_err;
   logic [31:0]       load_result;

   lsu_load_align u_load_align (
      .rdata   (mem_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (f3_q),
      .result  (load_result)
   );

   always_comb begin
      state_d      = state_q;
      f3_d         = f3_q;
      addr_lo_d    = addr_lo_q;
      mem_addr_d   = mem_addr_q;
      mem_rstrb_d  = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = 4'b0000;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      access_err   = lsu_access_err(req_bus.req_is_store, req_bus.req_funct3,
                                    req_bus.req_addr[1:0]);

      case (state_q)
         S_IDLE: begin
            if (req_bus.req_valid) begin
               f3_d      = req_bus.req_funct3;
               addr_lo_d = req_bus.req_addr[1:0];
               if (access_err) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  mem_addr_d = {req_bus.req_addr[ADDR_W-1:2], 2'b00};
                  if (req_bus.req_is_store) begin
                     state_d = S_WRITE;
                     case (req_bus.req_funct3)
                        F3_B: begin
                           mem_wdata_d = {4{req_bus.req_wdata[7:0]}};
                           mem_wmask_d = 4'b0001 << req_bus.req_addr[1:0];
                        end
                        F3_H: begin
                           mem_wdata_d = {2{req_bus.req_wdata[15:0]}};
                           mem_wmask_d = 4'b0011 << {req_bus.req_addr[1], 1'b0};
                        end
                        default: begin
                           mem_wdata_d = req_bus.req_wdata;
                           mem_wmask_d = 4'b1111;
                        end
                     endcase
                  end else begin
                     state_d     = S_READ;
                     mem_rstrb_d = 1'b1;
                  end
               end
            end
         end
         S_READ: state_d = S_WAIT;
         // Response flags are registered on entry to RESP so resp_valid is a clean flop output.
         S_WAIT: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
            resp_err_d   = 1'b0;
         end
         S_WRITE: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         f3_q         <= '0;
         addr_lo_q    <= '0;
         mem_addr_q   <= '0;
         mem_rstrb_q  <= 1'b0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         f3_q         <= f3_d;
         addr_lo_q    <= addr_lo_d;
         mem_addr_q   <= mem_addr_d;
         mem_rstrb_q  <= mem_rstrb_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_bus.req_ready  = (state_q == S_IDLE);
   assign req_bus.resp_valid = resp_valid_q;
   assign req_bus.resp_rdata = resp_rdata_q;
   assign req_bus.resp_err   = resp_err_q;
   assign mem_addr           = mem_addr_q;
   assign mem_rstrb          = mem_rstrb_q;
   assign mem_wdata          = mem_wdata_q;
   assign mem_wmask          = mem_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1-cycle-latency word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem [0:255];

   int unsigned checks   = 0;
   int unsigned failures = 0;

   load_store_unit_if #(.ADDR_W(32)) bus ();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_bus   (bus),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask)
   );

   always #5 clk = ~clk;

   // Memory model: samples strobes at the closing edge of the strobe cycle.
   always @(posedge clk) begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
         if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int unsigned lat,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_mask, input logic [31:0] exp_wd);
      @(negedge clk);
      chk("ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_funct3   = f3;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      @(posedge clk);
      #1;
      bus.req_valid    = 1'b0;
      bus.req_is_store = ~st;
      bus.req_funct3   = 3'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      for (int unsigned c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         chk("resp_valid", 32'(bus.resp_valid), 32'(c == lat));
         if (c == 1) begin
            chk("rstrb_c1", 32'(mem_rstrb), 32'(!st && !exp_err));
            chk("wmask_c1", 32'(mem_wmask), 32'(exp_mask));
            if (!exp_err) chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (st && !exp_err) chk("mem_wdata", mem_wdata, exp_wd);
         end else begin
            chk("rstrb_off", 32'(mem_rstrb), 32'd0);
            chk("wmask_off", 32'(mem_wmask), 32'd0);
         end
         if (c == lat) begin
            chk("resp_rdata", bus.resp_rdata, exp_rd);
            chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[100] = 32'h04030201;
      mem[101] = 32'h08070605;
      mem[103] = 32'hff0f0e0d;
      mem_rdata        = 32'h0;
      reset            = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_funct3   = 3'b000;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
      chk("rst_err", 32'(bus.resp_err), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_rstrb", 32'(mem_rstrb), 32'd0);
      chk("rst_wmask", 32'(mem_wmask), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // Loads: st, f3, addr, wdata, latency, rdata, err, wmask, wdata
      access(1'b0, 3'b010, 32'd400, 32'h0, 3, 32'h04030201, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b000, 32'd415, 32'h0, 3, 32'hffffffff, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b100, 32'd415, 32'h0, 3, 32'h000000ff, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b001, 32'd414, 32'h0, 3, 32'hffffff0f, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b101, 32'd412, 32'h0, 3, 32'h00000e0d, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b000, 32'd402, 32'h0, 3, 32'h00000003, 1'b0, 4'b0000, 32'h0);

      // Stores, then read back the merged words
      access(1'b1, 3'b000, 32'd401, 32'h000000ab, 2, 32'h0, 1'b0, 4'b0010, 32'habababab);
      access(1'b0, 3'b010, 32'd400, 32'h0, 3, 32'h0403ab01, 1'b0, 4'b0000, 32'h0);
      access(1'b1, 3'b001, 32'd406, 32'hdead1234, 2, 32'h0, 1'b0, 4'b1100, 32'h12341234);
      access(1'b1, 3'b010, 32'd408, 32'hcafef00d, 2, 32'h0, 1'b0, 4'b1111, 32'hcafef00d);
      access(1'b0, 3'b010, 32'd404, 32'h0, 3, 32'h12340605, 1'b0, 4'b0000, 32'h0);
      access(1'b0, 3'b010, 32'd408, 32'h0, 3, 32'hcafef00d, 1'b0, 4'b0000, 32'h0);

      // Errors: misaligned and illegal codes
      access(1'b0, 3'b010, 32'd402, 32'h0, 1, 32'h0, 1'b1, 4'b0000, 32'h0);
      access(1'b1, 3'b001, 32'd403, 32'h5555, 1, 32'h0, 1'b1, 4'b0000, 32'h0);
      access(1'b0, 3'b011, 32'd400, 32'h0, 1, 32'h0, 1'b1, 4'b0000, 32'h0);
      access(1'b1, 3'b100, 32'd400, 32'h77, 1, 32'h0, 1'b1, 4'b0000, 32'h0);
      access(1'b0, 3'b001, 32'd413, 32'h0, 1, 32'h0, 1'b1, 4'b0000, 32'h0);

      // req_valid held high: exactly one accept per response, next one after RESP
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b0;
      bus.req_funct3   = 3'b010;
      bus.req_addr     = 32'd412;
      @(negedge clk);
      chk("hold_ready_read", 32'(bus.req_ready), 32'd0);
      chk("hold_rstrb_read", 32'(mem_rstrb), 32'd1);
      @(negedge clk);
      chk("hold_ready_wait", 32'(bus.req_ready), 32'd0);
      chk("hold_rstrb_wait", 32'(mem_rstrb), 32'd0);
      @(negedge clk);
      chk("hold_ready_resp", 32'(bus.req_ready), 32'd0);
      chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'hff0f0e0d);
      @(negedge clk);
      chk("hold_ready_idle", 32'(bus.req_ready), 32'd1);
      chk("hold_rstrb_idle", 32'(mem_rstrb), 32'd0);
      @(negedge clk);
      chk("hold_second_rstrb", 32'(mem_rstrb), 32'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_second_resp", 32'(bus.resp_valid), 32'd1);
      chk("hold_second_rdata", bus.resp_rdata, 32'hff0f0e0d);

      // Reset while in WAIT abandons the load
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'd400;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("mid_rst_rdata", bus.resp_rdata, 32'd0);
      chk("mid_rst_err", 32'(bus.resp_err), 32'd0);
      chk("mid_rst_mem_addr", mem_addr, 32'd0);
      chk("mid_rst_rstrb", 32'(mem_rstrb), 32'd0);
      chk("mid_rst_wdata", mem_wdata, 32'd0);
      chk("mid_rst_wmask", 32'(mem_wmask), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      access(1'b0, 3'b010, 32'd404, 32'h0, 3, 32'h12340605, 1'b0, 4'b0000, 32'h0);
      mem[101] = 32'h08070605;
      access(1'b0, 3'b010, 32'd404, 32'h0, 3, 32'h08070605, 1'b0, 4'b0000, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Rstrb and wmask must never be asserted together.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (!(mem_rstrb && (|mem_wmask)))
         else begin
            failures++;
            $error("FAIL strobe_overlap observed=%b%b expected=not both", mem_rstrb, |mem_wmask);
         end
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the single-port word memory.
- Accepts one load/store request at a time; drives the memory's word address, read strobe, write data and byte write mask.
- Extracts and sign/zero-extends the loaded byte, halfword or word from the 1-cycle-latency memory read data, then returns a single-cycle response.
- Rejects misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, width of req_addr/mem_addr; bits [1:0] of mem_addr are always driven 0.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bits significant
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load result; 0 for stores/errors
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  out  ADDR_W  word-aligned address to memory, registered
- mem_rstrb  out  1  read strobe, registered, one-cycle pulse
- mem_rdata  in  32  memory read data, valid the cycle after the rstrb cycle
- mem_wdata  out  32  lane-replicated store data, registered
- mem_wmask  out  4  byte write enables, registered, nonzero for exactly one cycle per store

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - mem_addr, mem_rstrb, mem_wdata, mem_wmask, resp_valid, resp_rdata, resp_err all = 0.
  - Reset mid-operation abandons the access with no response.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other code is illegal and sets resp_err=1.
- Misaligned accesses set resp_err=1:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE (req_ready=1). On accept, latch funct3 and addr[1:0], then:
  - error -> RESP with resp_err=1, resp_rdata=0, no memory activity;
  - load -> mem_addr<={addr[31:2],2'b00}, mem_rstrb<=1, go READ;
  - store -> mem_addr likewise, mem_wdata/mem_wmask loaded, go WRITE.
- READ: mem_rstrb high this cycle (memory samples at the closing edge); clear mem_rstrb; go WAIT.
- WAIT: mem_rdata valid.
  - Select lane: byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1].
  - Extend: sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes through.
  - Register into resp_rdata; go RESP.
- WRITE: mem_wmask nonzero this cycle; clear mem_wmask to 0; go RESP. resp_rdata=0.
  - SB: wdata = {4{byte}}, wmask = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, wmask = 0011 << {addr[1],0}.
  - SW: wdata = req_wdata, wmask = 1111.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE. resp_rdata/resp_err hold until the next response.
- Latency from the accept cycle to resp_valid high:
  - load: 3 cycles;
  - store: 2 cycles;
  - error: 1 cycle.
- Throughput: next request accepted the cycle after RESP.
- req_valid while busy is ignored (req_ready=0); request fields need only be stable in the accept cycle.
- mem_addr holds its last value between accesses; mem_rstrb and mem_wmask are never high together.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding;
  - function for misaligned/illegal check.
- One combinational sub-module lsu_load_align (rdata, addr_lo[1:0], funct3 -> 32-bit extended result), instantiated in WAIT datapath and unit-testable alone.

Test Plan:
- Memory word 100 = 0x04030201:
  - LW addr 400 -> resp_rdata 0x04030201, resp_err 0;
  - mem_rstrb pulses 1 cycle after accept, mem_addr=400;
  - resp_valid 3 cycles after accept.
- Memory word 103 = 0xff0f0e0d:
  - LB addr 415 -> 0xffffffff;
  - LBU addr 415 -> 0x000000ff;
  - LH addr 414 -> 0xffffff0f;
  - LHU addr 412 -> 0x00000e0d.
- SB addr 401 wdata 0x000000AB -> mem_wdata 0xABABABAB, mem_wmask 0010 for one cycle, mem_addr 400, resp_valid 2 cycles after accept.
- LW addr 402, SH addr 403, and load funct3=011 -> resp_err=1 one cycle after accept; mem_rstrb and mem_wmask stay 0.
- req_valid held high continuously during a load -> only one accept; req_ready low in READ/WAIT/RESP; next accept in the cycle after RESP.
- reset asserted in WAIT -> next cycle state IDLE, all outputs 0, no resp_valid; a following LW addr 404 returns 0x08070605.
